// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller: FSM state encoding,
// frame header magic and byte width.
package alu_ctrl_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam logic [3:0]  HDR_MAGIC = 4'hA;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        ALU_REQ  = 3'd3,
        ALU_WAIT = 3'd4,
        TX_LO    = 3'd5,
        TX_HI    = 3'd6
    } state_t;

    // States that own the ALU or TX path and therefore refuse new RX bytes.
    function automatic logic rx_refused(input state_t s);
        return (s == ALU_REQ) || (s == ALU_WAIT) || (s == TX_LO) || (s == TX_HI);
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter; only instantiated when RX_TIMEOUT_EN is defined.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear outside the waiting states or on an accepted byte, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && !clr && (cnt_q == LIMIT);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command controller: receives header/A/B frames, drives an external ALU
// and returns the 2-byte result low byte first. Optional RX_TIMEOUT_EN adds an inter-byte timeout.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FUN_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     RX_DATA,
    input  logic                      RX_VALID,
    input  logic                      TX_BUSY,
    output logic [DATA_WIDTH-1:0]     TX_DATA,
    output logic                      TX_VALID,
    output logic [DATA_WIDTH-1:0]     ALU_A,
    output logic [DATA_WIDTH-1:0]     ALU_B,
    output logic [FUN_WIDTH-1:0]      ALU_FUN,
    output logic                      ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VALID,
    output logic                      CMD_ERR
);

    localparam int unsigned RES_W = 2 * DATA_WIDTH;

    state_t                 state_q,    state_d;
    logic [DATA_WIDTH-1:0]  alu_a_q,    alu_a_d;
    logic [DATA_WIDTH-1:0]  alu_b_q,    alu_b_d;
    logic [FUN_WIDTH-1:0]   alu_fun_q,  alu_fun_d;
    logic                   alu_en_q,   alu_en_d;
    logic [DATA_WIDTH-1:0]  tx_data_q,  tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   cmd_err_q,  cmd_err_d;
    logic [RES_W-1:0]       result_q,   result_d;

    logic tx_hs_s;
    logic hdr_ok_s;
    logic drop_s;
    logic proto_err_s;
    logic timeout_s;

    assign tx_hs_s  = tx_valid_q && !TX_BUSY;
    assign hdr_ok_s = (RX_DATA[DATA_WIDTH-1 -: 4] == HDR_MAGIC);
    assign drop_s   = RX_VALID && rx_refused(state_q);

`ifdef RX_TIMEOUT_EN
    logic wait_rx_s;
    assign wait_rx_s = (state_q == GET_A) || (state_q == GET_B);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .clk     (clk),
        .rst_n   (rst),
        .run     (wait_rx_s),
        .clr     (RX_VALID),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        alu_en_d    = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        result_d    = result_q;
        proto_err_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_VALID && hdr_ok_s) begin
                    alu_fun_d = RX_DATA[FUN_WIDTH-1:0];
                    state_d   = GET_A;
                end else if (RX_VALID) begin
                    proto_err_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GET_A: begin
                if (RX_VALID) begin
                    alu_a_d = RX_DATA;
                    state_d = GET_B;
                end else if (timeout_s) begin
                    proto_err_s = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = GET_A;
                end
            end
            GET_B: begin
                if (RX_VALID) begin
                    alu_b_d  = RX_DATA;
                    alu_en_d = 1'b1;
                    state_d  = ALU_REQ;
                end else if (timeout_s) begin
                    proto_err_s = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = GET_B;
                end
            end
            ALU_REQ: begin
                state_d = ALU_WAIT;
            end
            ALU_WAIT: begin
                if (ALU_OUT_VALID) begin
                    result_d   = ALU_OUT;
                    tx_data_d  = ALU_OUT[DATA_WIDTH-1:0];
                    tx_valid_d = 1'b1;
                    state_d    = TX_LO;
                end else begin
                    state_d = ALU_WAIT;
                end
            end
            // Low byte is re-driven from the result register while stalled, so it cannot drift.
            TX_LO: begin
                if (tx_hs_s) begin
                    tx_data_d = result_q[RES_W-1:DATA_WIDTH];
                    state_d   = TX_HI;
                end else begin
                    tx_data_d = result_q[DATA_WIDTH-1:0];
                end
            end
            TX_HI: begin
                if (tx_hs_s) begin
                    tx_data_d  = {DATA_WIDTH{1'b0}};
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = TX_HI;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = {DATA_WIDTH{1'b0}};
            end
        endcase
        cmd_err_d = proto_err_s || drop_s;
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            alu_a_q    <= {DATA_WIDTH{1'b0}};
            alu_b_q    <= {DATA_WIDTH{1'b0}};
            alu_fun_q  <= {FUN_WIDTH{1'b0}};
            alu_en_q   <= 1'b0;
            tx_data_q  <= {DATA_WIDTH{1'b0}};
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            result_q   <= {RES_W{1'b0}};
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
            result_q   <= result_d;
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;
    assign ALU_FUN  = alu_fun_q;
    assign ALU_EN   = alu_en_q;
    assign CMD_ERR  = cmd_err_q;

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the operand and byte width.
REQ-002 The block SHALL have parameter FUN_WIDTH, default 4, meaning the ALU function-select width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the inter-byte timeout in clk cycles (used only under REQ-024).
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  in  1  meaning the reset, asynchronous and active-low.
REQ-006 The block SHALL have port RX_DATA  in  DATA_WIDTH  meaning the received byte.
REQ-007 The block SHALL have port RX_VALID  in  1  meaning RX_DATA is valid for this one cycle.
REQ-008 The block SHALL have port TX_BUSY  in  1  meaning the transmitter cannot accept a byte.
REQ-009 The block SHALL have port TX_DATA  out  DATA_WIDTH  meaning the byte to transmit.
REQ-010 The block SHALL have port TX_VALID  out  1  meaning TX_DATA is offered.
REQ-011 The block SHALL have ports ALU_A, ALU_B  out  DATA_WIDTH  meaning the operands driven to the ALU.
REQ-012 The block SHALL have ports ALU_FUN  out  FUN_WIDTH  and ALU_EN  out  1  meaning the function select and a single-cycle ALU enable.
REQ-013 The block SHALL have ports ALU_OUT  in  2*DATA_WIDTH  and ALU_OUT_VALID  in  1  meaning the registered ALU result and its valid flag.
REQ-014 The block SHALL have port CMD_ERR  out  1  meaning a one-cycle pulse on a protocol error.

Function
REQ-015 The block SHALL accept a frame of three RX bytes: header, then A, then B; the header's upper nibble SHALL be 4'hA and its lower FUN_WIDTH bits SHALL be the function code.
REQ-016 The FSM SHALL have states IDLE, GET_A, GET_B, ALU_REQ, ALU_WAIT, TX_LO and TX_HI, with transitions IDLE->GET_A (valid header), GET_A->GET_B (RX_VALID), GET_B->ALU_REQ (RX_VALID), ALU_REQ->ALU_WAIT (always), ALU_WAIT->TX_LO (ALU_OUT_VALID), TX_LO->TX_HI and TX_HI->IDLE (each on a handshake).
REQ-017 In IDLE, a header whose upper nibble is not 4'hA SHALL be dropped, SHALL pulse CMD_ERR for one cycle and SHALL leave the state in IDLE.
REQ-018 ALU_A, ALU_B and ALU_FUN SHALL be registered, SHALL hold stable from byte capture through ALU_WAIT, and ALU_EN SHALL be high only during the single ALU_REQ cycle.
REQ-019 Timing SHALL be as follows: if B is captured at edge N, then ALU_EN is high in cycle N+1, ALU_OUT_VALID is expected in cycle N+2, the result is captured at the end of that cycle, and TX_VALID with the low byte is high in cycle N+3.
REQ-020 A TX byte SHALL transfer on a cycle where TX_VALID=1 and TX_BUSY=0; TX_DATA SHALL be held stable while TX_BUSY=1; the low byte (ALU_OUT[7:0]) SHALL be sent first, then the high byte; TX_VALID SHALL be 0 in IDLE.
REQ-021 An RX_VALID arriving in ALU_REQ, ALU_WAIT, TX_LO or TX_HI SHALL be dropped and SHALL pulse CMD_ERR; the result and the state SHALL be unaffected.
REQ-022 A back-to-back frame whose header arrives in the cycle after the TX_HI handshake SHALL be accepted normally.

Reset
REQ-023 On rst low, at any time including mid-frame or mid-TX, the state SHALL become IDLE and TX_DATA, TX_VALID, ALU_A, ALU_B, ALU_FUN, ALU_EN, CMD_ERR and the result register SHALL all be 0 immediately.

Configuration
REQ-024 With RX_TIMEOUT_EN defined, a counter SHALL clear on each accepted byte, and if TIMEOUT_CYC cycles elapse in GET_A or GET_B without RX_VALID, the block SHALL pulse CMD_ERR and return to IDLE; without RX_TIMEOUT_EN, no counter SHALL exist and GET_A and GET_B SHALL wait indefinitely.

Structure
REQ-025 The shared package alu_ctrl_pkg SHALL hold the state enum typedef, the header constant 4'hA and the byte-width constant.
REQ-026 The timeout counter SHALL be one sub-module, frame_timer, instantiated only under RX_TIMEOUT_EN; all other logic SHALL be flat.

Verification
REQ-027 RX A0,05,03 with a model ALU (1-cycle latency) and TX_BUSY=0 -> ALU_EN 1 cycle with A=05, B=03, FUN=0; TX bytes 08 then 00.
REQ-028 RX A2,FF,FF with TX_BUSY high for 5 cycles -> TX_DATA held at 01 during the stall, then bytes 01 then FE.
REQ-029 RX header 35 -> one-cycle CMD_ERR pulse, no ALU_EN; a following A4,0F,3C -> bytes 0C, 00.
REQ-030 RX byte during ALU_WAIT -> one-cycle CMD_ERR pulse, result bytes unchanged.
REQ-031 rst asserted in TX_HI -> all outputs 0 at once; the next frame A1,09,04 -> bytes 05, 00.
REQ-032 With RX_TIMEOUT_EN and TIMEOUT_CYC=16, RX A0 then silence -> CMD_ERR at cycle 16 and IDLE; without the macro -> still in GET_A.
